// File: rtl/lfsr_pkg.sv
// Shared polynomial definition for the 10-bit LFSR generator and checker.
// Both ends import this so the sequence cannot drift apart.
package lfsr_pkg;

    localparam int LFSR_W = 10;
    localparam int TAP_HI = 9;
    localparam int TAP_LO = 6;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_e;

    // x^10 + x^7 + 1, period 1023; all-zero is the lock-up value
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] v
    );
        return {v[LFSR_W-2:0], v[TAP_HI] ^ v[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: hunts for the sequence, verifies it,
// then free-runs its prediction and flags every beat that breaks it.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] in_value,
    output logic              locked,
    output logic              error,
    output logic [CNT_W-1:0]  err_count
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W = $clog2(UNLOCK_COUNT + 1);

    state_e             state_q;
    logic [LFSR_W-1:0]  expected_q;
    logic [RUN_W-1:0]   run_q;
    logic [RUN_W-1:0]   run_d;
    logic [BAD_W-1:0]   bad_q;
    logic [BAD_W-1:0]   bad_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               locked_q;
    logic               error_q;

    logic               is_zero;
    logic               hit;
    logic [LFSR_W-1:0]  exp_adv;
    logic [LFSR_W-1:0]  seed;

    assign is_zero = (in_value == '0);
    assign hit     = (in_value == expected_q);
    assign exp_adv = lfsr_next(expected_q);
    assign seed    = lfsr_next(in_value);

    assign run_d = run_q + RUN_W'(1);
    assign bad_d = bad_q + BAD_W'(1);
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            expected_q <= '0;
            run_q      <= '0;
            bad_q      <= '0;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            error_q <= 1'b0;
            if (in_valid) begin
                unique case (state_q)
                    HUNT: begin
                        if (!is_zero) begin
                            expected_q <= seed;
                            run_q      <= '0;
                            state_q    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (is_zero) begin
                            state_q <= HUNT;
                        end else if (hit) begin
                            expected_q <= exp_adv;
                            run_q      <= run_d;
                            if (run_d == RUN_W'(LOCK_COUNT)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                bad_q    <= '0;
                            end
                        end else begin
                            expected_q <= seed;
                            run_q      <= '0;
                        end
                    end
                    LOCKED: begin
                        // Once locked, the prediction never reseeds
                        expected_q <= exp_adv;
                        if (hit) begin
                            bad_q <= '0;
                        end else begin
                            error_q <= 1'b1;
                            cnt_q   <= cnt_d;
                            bad_q   <= bad_d;
                            if (bad_d == BAD_W'(UNLOCK_COUNT)) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign error     = error_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios plus a randomized stream
// compared against a behavioural model of the lock/verify rules.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  in_value = '0;
    logic        locked;
    logic        error;
    logic [15:0] err_count;
    logic        locked_s;
    logic        error_s;
    logic [3:0]  err_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_value  (in_value),
        .locked    (locked),
        .error     (error),
        .err_count (err_count)
    );

    lfsr_checker #(
        .LOCK_COUNT   (4),
        .UNLOCK_COUNT (32),
        .CNT_W        (4)
    ) dut_s (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_value  (in_value),
        .locked    (locked_s),
        .error     (error_s),
        .err_count (err_count_s)
    );

    // Reference model: index 0 = default build, 1 = saturation build
    int         lock_n[2]   = '{4, 4};
    int         unlock_n[2] = '{3, 32};
    int         cnt_max[2]  = '{65535, 15};
    int         m_mode[2];   // 0 hunting, 1 verifying, 2 locked
    int         m_exp[2];
    int         m_run[2];
    int         m_bad[2];
    int         m_cnt[2];
    bit         m_err[2];

    function automatic int nx(input int x);
        int fb;
        fb = ((x / 512) % 2) ^ ((x / 64) % 2);
        return ((x * 2) % 1024) + fb;
    endfunction

    task automatic model_step(input int i, input bit rst,
                              input bit vld, input int v);
        if (rst) begin
            m_mode[i] = 0; m_exp[i] = 0; m_run[i] = 0;
            m_bad[i] = 0;  m_cnt[i] = 0; m_err[i] = 0;
            return;
        end
        m_err[i] = 0;
        if (!vld) return;
        if (m_mode[i] == 0) begin
            if (v != 0) begin
                m_exp[i] = nx(v); m_run[i] = 0; m_mode[i] = 1;
            end
        end else if (m_mode[i] == 1) begin
            if (v == 0) m_mode[i] = 0;
            else if (v == m_exp[i]) begin
                m_exp[i] = nx(m_exp[i]);
                m_run[i]++;
                if (m_run[i] == lock_n[i]) begin
                    m_mode[i] = 2; m_bad[i] = 0;
                end
            end else begin
                m_exp[i] = nx(v); m_run[i] = 0;
            end
        end else begin
            if (v == m_exp[i]) m_bad[i] = 0;
            else begin
                m_err[i] = 1;
                if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
                m_bad[i]++;
                if (m_bad[i] == unlock_n[i]) m_mode[i] = 0;
            end
            m_exp[i] = nx(m_exp[i]);
        end
    endtask

    task automatic beat(input bit vld, input logic [9:0] v,
                        input bit rst);
        reset = rst; in_valid = vld; in_value = v;
        @(posedge clk);
        model_step(0, rst, vld, int'(v));
        model_step(1, rst, vld, int'(v));
        #1;
        reset = 1'b0; in_valid = 1'b0; in_value = '0;
    endtask

    logic [9:0] seq[6] = '{10'h001, 10'h002, 10'h004,
                           10'h008, 10'h010, 10'h020};

    task automatic test_reset();
        beat(1'b1, 10'h001, 1'b1);
        checks += 4;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL reset_locked got=%0b want=0", locked);
        end
        if (error !== 1'b0) begin
            errors++; $display("FAIL reset_error got=%0b want=0", error);
        end
        if (err_count !== 16'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d want=0", err_count);
        end
        if (err_count_s !== 4'd0) begin
            errors++; $display("FAIL reset_cnt_s got=%0d want=0", err_count_s);
        end
    endtask

    task automatic test_lock();
        beat(1'b0, 10'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, seq[i], 1'b0);
            checks += 3;
            if (locked !== (i == 4)) begin
                errors++;
                $display("FAIL lock_b%0d locked got=%0b want=%0b",
                         i, locked, i == 4);
            end
            if (error !== 1'b0) begin
                errors++; $display("FAIL lock_b%0d error got=%0b want=0", i, error);
            end
            if (err_count !== 16'd0) begin
                errors++; $display("FAIL lock_b%0d cnt got=%0d want=0", i, err_count);
            end
        end
    endtask

    task automatic test_single_error();
        beat(1'b0, 10'h0, 1'b1);
        for (int i = 0; i < 6; i++) beat(1'b1, seq[i], 1'b0);
        beat(1'b1, 10'h3FF, 1'b0);
        checks += 3;
        if (error !== 1'b1) begin
            errors++; $display("FAIL single_err_pulse got=%0b want=1", error);
        end
        if (err_count !== 16'd1) begin
            errors++; $display("FAIL single_err_cnt got=%0d want=1", err_count);
        end
        if (locked !== 1'b1) begin
            errors++; $display("FAIL single_err_locked got=%0b want=1", locked);
        end
        beat(1'b1, 10'h081, 1'b0);
        checks += 3;
        if (error !== 1'b0) begin
            errors++; $display("FAIL freerun_pulse got=%0b want=0", error);
        end
        if (err_count !== 16'd1) begin
            errors++; $display("FAIL freerun_cnt got=%0d want=1", err_count);
        end
        if (locked !== 1'b1) begin
            errors++; $display("FAIL freerun_locked got=%0b want=1", locked);
        end
    endtask

    task automatic test_unlock();
        beat(1'b0, 10'h0, 1'b1);
        for (int i = 0; i < 5; i++) beat(1'b1, seq[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 10'h155, 1'b0);
            checks += 3;
            if (error !== 1'b1) begin
                errors++; $display("FAIL unlock_b%0d error got=%0b want=1", i, error);
            end
            if (err_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL unlock_b%0d cnt got=%0d want=%0d", i, err_count, i + 1);
            end
            if (locked !== (i != 2)) begin
                errors++;
                $display("FAIL unlock_b%0d locked got=%0b want=%0b", i, locked, i != 2);
            end
        end
        for (int i = 0; i < 5; i++) beat(1'b1, seq[i], 1'b0);
        checks += 3;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL relock locked got=%0b want=1", locked);
        end
        if (err_count !== 16'd3) begin
            errors++; $display("FAIL relock cnt got=%0d want=3", err_count);
        end
        if (error !== 1'b0) begin
            errors++; $display("FAIL relock error got=%0b want=0", error);
        end
    endtask

    task automatic test_hunt_gaps();
        beat(1'b0, 10'h0, 1'b1);
        for (int i = 0; i < 3; i++) beat(1'b1, 10'h000, 1'b0);
        beat(1'b1, 10'h001, 1'b0);
        beat(1'b1, 10'h002, 1'b0);
        beat(1'b1, 10'h000, 1'b0);
        for (int i = 2; i < 6; i++) beat(1'b1, seq[i], 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL zero_to_hunt locked got=%0b want=0", locked);
        end
        beat(1'b1, 10'h040, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL hunt_relock locked got=%0b want=1", locked);
        end
        beat(1'b0, 10'h0, 1'b1);
        beat(1'b1, 10'h001, 1'b0);
        beat(1'b1, 10'h002, 1'b0);
        for (int i = 0; i < 5; i++) begin
            beat(1'b0, 10'h3FF, 1'b0);
            checks++;
            if (locked !== 1'b0) begin
                errors++; $display("FAIL gap_idle%0d locked got=%0b want=0", i, locked);
            end
        end
        for (int i = 2; i < 5; i++) beat(1'b1, seq[i], 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL gap_lock locked got=%0b want=1", locked);
        end
    endtask

    task automatic test_reset_mid_lock();
        beat(1'b0, 10'h0, 1'b1);
        for (int i = 0; i < 5; i++) beat(1'b1, seq[i], 1'b0);
        beat(1'b1, 10'h155, 1'b0);
        checks++;
        if (error !== 1'b1) begin
            errors++; $display("FAIL midlock_pre error got=%0b want=1", error);
        end
        beat(1'b1, 10'h155, 1'b1);
        checks += 3;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL midlock_rst locked got=%0b want=0", locked);
        end
        if (error !== 1'b0) begin
            errors++; $display("FAIL midlock_rst error got=%0b want=0", error);
        end
        if (err_count !== 16'd0) begin
            errors++; $display("FAIL midlock_rst cnt got=%0d want=0", err_count);
        end
        for (int i = 0; i < 5; i++) beat(1'b1, seq[i], 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL midlock_resume locked got=%0b want=1", locked);
        end
    endtask

    task automatic test_saturation();
        logic [9:0] bad;
        beat(1'b0, 10'h0, 1'b1);
        for (int i = 0; i < 5; i++) beat(1'b1, seq[i], 1'b0);
        for (int i = 0; i < 20; i++) begin
            bad = 10'(m_exp[1]) ^ 10'h155;
            beat(1'b1, bad, 1'b0);
            checks += 3;
            if (error_s !== 1'b1) begin
                errors++; $display("FAIL sat_b%0d error got=%0b want=1", i, error_s);
            end
            if (err_count_s !== 4'((i < 15) ? i + 1 : 15)) begin
                errors++;
                $display("FAIL sat_b%0d cnt got=%0d want=%0d",
                         i, err_count_s, (i < 15) ? i + 1 : 15);
            end
            if (locked_s !== 1'b1) begin
                errors++; $display("FAIL sat_b%0d locked got=%0b want=1", i, locked_s);
            end
        end
    endtask

    task automatic test_random();
        int g;
        int r;
        bit vld;
        bit rst;
        int v;
        beat(1'b0, 10'h0, 1'b1);
        g = $urandom_range(1, 1023);
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            rst = (r == 99);
            vld = (r >= 20);
            v = g;
            if (r >= 20 && r < 25) v = $urandom_range(0, 1023);
            else if (r >= 25 && r < 27) v = 0;
            else if (r >= 27 && r < 29) begin
                g = $urandom_range(1, 1023); v = g;
            end
            if (vld) g = nx(g);
            beat(vld, 10'(v), rst);
            checks += 6;
            if (locked !== (m_mode[0] == 2)) begin
                errors++; $display("FAIL rnd%0d locked got=%0b want=%0b", n, locked, m_mode[0] == 2);
            end
            if (error !== m_err[0]) begin
                errors++; $display("FAIL rnd%0d error got=%0b want=%0b", n, error, m_err[0]);
            end
            if (err_count !== 16'(m_cnt[0])) begin
                errors++; $display("FAIL rnd%0d cnt got=%0d want=%0d", n, err_count, m_cnt[0]);
            end
            if (locked_s !== (m_mode[1] == 2)) begin
                errors++; $display("FAIL rnd%0d locked_s got=%0b want=%0b", n, locked_s, m_mode[1] == 2);
            end
            if (error_s !== m_err[1]) begin
                errors++; $display("FAIL rnd%0d error_s got=%0b want=%0b", n, error_s, m_err[1]);
            end
            if (err_count_s !== 4'(m_cnt[1])) begin
                errors++; $display("FAIL rnd%0d cnt_s got=%0d want=%0d", n, err_count_s, m_cnt[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_unlock();
        test_hunt_gaps();
        test_reset_mid_lock();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
